// File: rtl/alu_arb_pkg.sv
// Shared constants for the ALU share arbiter: ALU operation codes, port
// indices and the operation driven onto the ALU while no port is granted.
package alu_arb_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0111;

  // ADD with zero operands keeps the ALU inputs quiet between requests.
  localparam logic [3:0] ALU_IDLE_OP = ALU_ADD;

  localparam int PORT_EX   = 0;
  localparam int PORT_BR   = 1;
  localparam int NUM_PORTS = 2;

endpackage

// File: rtl/alu_arb_rsp_slot.sv
// One response slot: holds an ALU result plus its zero flag until the
// consumer takes it. A clear drops the slot regardless of the handshake.
module alu_arb_rsp_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic             rsp_ready,
  input  logic [WIDTH-1:0] d_result,
  input  logic             d_zero,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             free
);

  // Slot accepts a new result when empty or being drained this cycle.
  always_comb begin
    free = ~rsp_valid | rsp_ready;
  end

  // Slot state: clear wins, then refill, then drain; data only moves on load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      if (clear) begin
        rsp_valid <= 1'b0;
      end else if (load) begin
        rsp_valid <= 1'b1;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if (load && !clear) begin
        rsp_result <= d_result;
        rsp_zero   <= d_zero;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the EX stage (port 0) and the
// branch-compare unit (port 1). One grant per cycle, result registered into
// a per-port response slot one cycle later.
// Build option: define ALU_ARB_ROUND_ROBIN_EN for round-robin tie breaking;
// otherwise port 0 wins every tie and no pointer register exists.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][OPW-1:0]   req_op,
  input  logic [1:0][WIDTH-1:0] req_a,
  input  logic [1:0][WIDTH-1:0] req_b,
  input  logic                  flush0,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [OPW-1:0]        alu_op,
  input  logic [WIDTH-1:0]      alu_result,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [1:0][WIDTH-1:0] rsp_result,
  output logic [1:0]            rsp_zero
);

  logic [1:0] free_p0;
  logic [1:0] elig_p0;
  logic [1:0] grant_p0;
  logic       tie_to_ex;
  logic       zero_p0;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic last_grant;  // 1: port 1 was granted last, so port 0 wins the next tie

  // Remember which port won most recently; reset favours port 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (|grant_p0) begin
      last_grant <= grant_p0[PORT_BR];
    end
  end

  // Tie goes to the port not granted last.
  always_comb begin
    tie_to_ex = last_grant;
  end
`else
  // Fixed priority: EX always wins a tie.
  always_comb begin
    tie_to_ex = 1'b1;
  end
`endif

  // Eligibility and one-hot grant; nothing is granted while reset is held.
  always_comb begin
    elig_p0[PORT_EX] = rst_n & req_valid[PORT_EX] & free_p0[PORT_EX] & ~flush0;
    elig_p0[PORT_BR] = rst_n & req_valid[PORT_BR] & free_p0[PORT_BR];
    grant_p0 = 2'b00;
    if (elig_p0[PORT_EX] && (!elig_p0[PORT_BR] || tie_to_ex)) begin
      grant_p0[PORT_EX] = 1'b1;
    end else if (elig_p0[PORT_BR]) begin
      grant_p0[PORT_BR] = 1'b1;
    end
    req_ready = grant_p0;
  end

  // Drive the shared ALU from the winner, or park it on ADD 0,0 when idle.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = OPW'(ALU_IDLE_OP);
    if (grant_p0[PORT_EX]) begin
      alu_a  = req_a[PORT_EX];
      alu_b  = req_b[PORT_EX];
      alu_op = req_op[PORT_EX];
    end else if (grant_p0[PORT_BR]) begin
      alu_a  = req_a[PORT_BR];
      alu_b  = req_b[PORT_BR];
      alu_op = req_op[PORT_BR];
    end
    zero_p0 = ~|alu_result;
  end

  // ---- stage boundary: ALU result captured into response slots ----
  alu_arb_rsp_slot #(.WIDTH(WIDTH)) u_slot_ex (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (grant_p0[PORT_EX]),
    .clear      (flush0),
    .rsp_ready  (rsp_ready[PORT_EX]),
    .d_result   (alu_result),
    .d_zero     (zero_p0),
    .rsp_valid  (rsp_valid[PORT_EX]),
    .rsp_result (rsp_result[PORT_EX]),
    .rsp_zero   (rsp_zero[PORT_EX]),
    .free       (free_p0[PORT_EX])
  );

  alu_arb_rsp_slot #(.WIDTH(WIDTH)) u_slot_br (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (grant_p0[PORT_BR]),
    .clear      (1'b0),
    .rsp_ready  (rsp_ready[PORT_BR]),
    .d_result   (alu_result),
    .d_zero     (zero_p0),
    .rsp_valid  (rsp_valid[PORT_BR]),
    .rsp_result (rsp_result[PORT_BR]),
    .rsp_zero   (rsp_zero[PORT_BR]),
    .free       (free_p0[PORT_BR])
  );

endmodule
